// File: rtl/alu4bit_responder_if.sv
// Request/response bundle for the ALU responder.
// The master side issues {a, b, sel} requests and consumes responses; the slave side
// (the responder) accepts requests and presents buffered results.
// Macro ALU_RSP_FLAGS_EN adds the rsp_zero / rsp_neg result flags to the bundle.
interface alu4bit_responder_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic [CNT_W-1:0] rsp_count;
`ifdef ALU_RSP_FLAGS_EN
    logic             rsp_zero;
    logic             rsp_neg;
`endif

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
`ifdef ALU_RSP_FLAGS_EN
        , input rsp_zero, rsp_neg
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
`ifdef ALU_RSP_FLAGS_EN
        , output rsp_zero, rsp_neg
`endif
    );
endinterface

// File: rtl/alu4bit_responder.sv
// ALU request/response responder.
// Requests {a, b, sel} are evaluated combinationally (ADD/SUB/AND/OR) and written into a
// DEPTH-entry response FIFO at the accept edge; results leave in order on the response
// channel. All outputs come from flops, so there is no combinational req_* -> rsp_* path.
// Macro ALU_RSP_FLAGS_EN adds per-entry zero/negative flags on rsp_zero / rsp_neg.
module alu4bit_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,   // power of 2, >= 2
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu4bit_responder_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
`ifdef ALU_RSP_FLAGS_EN
        logic             zero;
        logic             neg;
`endif
    } entry_t;

    state_e           state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    entry_t           alu_entry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             push;
    logic             pop;

    assign push = bus.req_valid && req_ready_q;
    assign pop  = rsp_valid_q && bus.rsp_ready;

    // ALU: evaluate the presented request into a FIFO entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        alu_entry = '0;
        sum       = {1'b0, bus.req_a} + {1'b0, bus.req_b};
        diff      = {1'b0, bus.req_a} - {1'b0, bus.req_b};
        unique case (bus.req_sel)
            2'b00: begin
                alu_entry.result = sum[WIDTH-1:0];
                alu_entry.carry  = sum[WIDTH];
            end
            2'b01: begin
                // The extra bit of the widened difference is the borrow (a < b).
                alu_entry.result = diff[WIDTH-1:0];
                alu_entry.carry  = diff[WIDTH];
            end
            2'b10:   alu_entry.result = bus.req_a & bus.req_b;
            default: alu_entry.result = bus.req_a | bus.req_b;
        endcase
`ifdef ALU_RSP_FLAGS_EN
        alu_entry.zero = (alu_entry.result == '0);
        alu_entry.neg  = alu_entry.result[WIDTH-1];
`endif
    end

    // Next-state: FIFO control FSM, occupancy, pointers, storage and delivery counter.
    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && occ_q == OCC_W'(DEPTH - 1)) begin
                    state_d = ST_FULL;
                end else if (pop && !push && occ_q == OCC_W'(1)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = alu_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end

        req_ready_d = (state_d != ST_FULL);
        rsp_valid_d = (state_d != ST_EMPTY);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            state_q     <= ST_EMPTY;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            // NOTE: the storage is reset too, because the head entry drives rsp_result
            // directly and must read 0 after reset; with a tiny FIFO this is cheap.
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = mem_q[rd_ptr_q].result;
    assign bus.rsp_carry  = mem_q[rd_ptr_q].carry;
    assign bus.rsp_count  = count_q;
`ifdef ALU_RSP_FLAGS_EN
    assign bus.rsp_zero   = mem_q[rd_ptr_q].zero;
    assign bus.rsp_neg    = mem_q[rd_ptr_q].neg;
`endif

endmodule
